// File: rtl/lsu_stb_dcache_arbiter.sv
// LSU load / store-buffer drain arbiter for the single dcache port.
// Handles load-after-store ordering, store anti-starvation and fence drain.
module lsu_stb_dcache_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                lsu2arb_ld_req,
   input  logic [ADDR_W-1:0]   lsu2arb_ld_addr,
   input  logic [DATA_W/8-1:0] lsu2arb_ld_sel_byte,
   input  logic                ld_hit_stb,
   output logic                arb2lsu_ld_ack,
   output logic [DATA_W-1:0]   arb2lsu_ld_rdata,
   input  logic                stb2arb_req,
   input  logic [ADDR_W-1:0]   stb2arb_addr,
   input  logic [DATA_W-1:0]   stb2arb_wdata,
   input  logic [DATA_W/8-1:0] stb2arb_sel_byte,
   input  logic                stb_full,
   input  logic                stb_empty,
   output logic                arb2stb_ack,
   input  logic                fence_drain_i,
   output logic                arb2lsu_drain_done,
   output logic                arb2dcache_req,
   output logic                arb2dcache_w_en,
   output logic [ADDR_W-1:0]   arb2dcache_addr,
   output logic [DATA_W-1:0]   arb2dcache_wdata,
   output logic [DATA_W/8-1:0] arb2dcache_sel_byte,
   input  logic                dcache2arb_ack,
   input  logic [DATA_W-1:0]   dcache2arb_rdata
);

   localparam int SEL_W = DATA_W / 8;
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [1:0] ARB_IDLE    = 2'd0;
   localparam logic [1:0] ARB_LD_WAIT = 2'd1;
   localparam logic [1:0] ARB_ST_WAIT = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic              drain_pending_q, drain_pending_d;
   logic              req_q, req_d;
   logic              w_en_q, w_en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [SEL_W-1:0]  sel_q, sel_d;

   logic in_idle;
   logic cnt_sat;
   logic st_win;
   logic gnt_ld;
   logic gnt_st;
   logic drain_done;

   // Idle-cycle grant decision; forced stores beat loads
   always_comb begin
      in_idle = (state_q == ARB_IDLE);
      cnt_sat = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
      st_win  = stb2arb_req &
                (drain_pending_q | stb_full | cnt_sat |
                 (lsu2arb_ld_req & ld_hit_stb));
      gnt_ld  = in_idle & ~st_win &
                lsu2arb_ld_req & ~drain_pending_q;
      gnt_st  = in_idle & stb2arb_req & ~gnt_ld;
      drain_done = in_idle & drain_pending_q & stb_empty;
   end

   // FSM and registered dcache request bus
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      w_en_d  = w_en_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      sel_d   = sel_q;
      unique case (state_q)
         ARB_IDLE: begin
            unique case (1'b1)
               gnt_ld: begin
                  state_d = ARB_LD_WAIT;
                  req_d   = 1'b1;
                  w_en_d  = 1'b0;
                  addr_d  = lsu2arb_ld_addr;
                  wdata_d = '0;
                  sel_d   = lsu2arb_ld_sel_byte;
               end
               gnt_st: begin
                  state_d = ARB_ST_WAIT;
                  req_d   = 1'b1;
                  w_en_d  = 1'b1;
                  addr_d  = stb2arb_addr;
                  wdata_d = stb2arb_wdata;
                  sel_d   = stb2arb_sel_byte;
               end
               default: ;
            endcase
         end
         ARB_LD_WAIT, ARB_ST_WAIT: begin
            if (dcache2arb_ack) begin
               state_d = ARB_IDLE;
               req_d   = 1'b0;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // Starvation counter and fence bookkeeping
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (stb_empty || gnt_st)
         starve_cnt_d = '0;
      else if (gnt_ld && !cnt_sat)
         starve_cnt_d = starve_cnt_q + 1'b1;
      drain_pending_d = drain_pending_q;
      if (fence_drain_i)
         drain_pending_d = 1'b1;
      else if (drain_done)
         drain_pending_d = 1'b0;
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ARB_IDLE;
         starve_cnt_q    <= '0;
         drain_pending_q <= 1'b0;
         req_q           <= 1'b0;
         w_en_q          <= 1'b0;
         addr_q          <= '0;
         wdata_q         <= '0;
         sel_q           <= '0;
      end else begin
         state_q         <= state_d;
         starve_cnt_q    <= starve_cnt_d;
         drain_pending_q <= drain_pending_d;
         req_q           <= req_d;
         w_en_q          <= w_en_d;
         addr_q          <= addr_d;
         wdata_q         <= wdata_d;
         sel_q           <= sel_d;
      end
   end

   assign arb2lsu_ld_ack      = (state_q == ARB_LD_WAIT) & dcache2arb_ack;
   assign arb2lsu_ld_rdata    = arb2lsu_ld_ack ? dcache2arb_rdata : '0;
   assign arb2stb_ack         = (state_q == ARB_ST_WAIT) & dcache2arb_ack;
   assign arb2lsu_drain_done  = drain_done;
   assign arb2dcache_req      = req_q;
   assign arb2dcache_w_en     = w_en_q;
   assign arb2dcache_addr     = addr_q;
   assign arb2dcache_wdata    = wdata_q;
   assign arb2dcache_sel_byte = sel_q;

endmodule

// File: tb/tb_lsu_stb_dcache_arbiter.sv
// Bench for lsu_stb_dcache_arbiter: queue-based store buffer, LSU and
// dcache models with a transaction scoreboard and rule monitor.
module tb_lsu_stb_dcache_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int LIM = 4;
   localparam int DEP = 4;

   logic          clk;
   logic          rst_n;
   logic          ld_req;
   logic [AW-1:0] ld_addr;
   logic [SW-1:0] ld_sel;
   logic          ld_hit;
   logic          ld_ack;
   logic [DW-1:0] ld_rdata;
   logic          st_req;
   logic [AW-1:0] st_addr;
   logic [DW-1:0] st_wdata;
   logic [SW-1:0] st_sel;
   logic          st_full;
   logic          st_empty;
   logic          st_ack;
   logic          fence;
   logic          done;
   logic          dc_req;
   logic          dc_wen;
   logic [AW-1:0] dc_addr;
   logic [DW-1:0] dc_wdata;
   logic [SW-1:0] dc_sel;
   logic          dc_ack;
   logic [DW-1:0] dc_rdata;

   lsu_stb_dcache_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .lsu2arb_ld_req(ld_req),
      .lsu2arb_ld_addr(ld_addr),
      .lsu2arb_ld_sel_byte(ld_sel),
      .ld_hit_stb(ld_hit),
      .arb2lsu_ld_ack(ld_ack),
      .arb2lsu_ld_rdata(ld_rdata),
      .stb2arb_req(st_req),
      .stb2arb_addr(st_addr),
      .stb2arb_wdata(st_wdata),
      .stb2arb_sel_byte(st_sel),
      .stb_full(st_full),
      .stb_empty(st_empty),
      .arb2stb_ack(st_ack),
      .fence_drain_i(fence),
      .arb2lsu_drain_done(done),
      .arb2dcache_req(dc_req),
      .arb2dcache_w_en(dc_wen),
      .arb2dcache_addr(dc_addr),
      .arb2dcache_wdata(dc_wdata),
      .arb2dcache_sel_byte(dc_sel),
      .dcache2arb_ack(dc_ack),
      .dcache2arb_rdata(dc_rdata)
   );

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
   } st_t;
   typedef struct {
      logic [AW-1:0] a;
      logic [SW-1:0] s;
   } ld_t;
   typedef struct {
      bit            w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } tx_t;

   st_t stbq[$];
   ld_t ldq[$];
   tx_t txlog[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int dc_lat = 1;
   int wait_cnt = 0;
   bit rnd_lat = 0;
   bit pop_st = 0;
   bit pop_ld = 0;
   bit fence_req = 0;
   int fence_cyc = 0;
   int done_cyc = 0;
   int done_cnt = 0;
   int ld_rise_cyc = 0;
   int req_rise_cyc = 0;
   int st_ack_cnt = 0;
   int ld_ack_cnt = 0;
   logic [DW-1:0] last_rd = '0;

   bit req_prev = 0;
   bit prev_hit = 0;
   bit prev_pend = 0;
   bit prev_ne = 0;
   bit pend = 0;
   int consec = 0;
   bit snap_w = 0;
   logic [AW-1:0] snap_a = '0;
   logic [DW-1:0] snap_d = '0;
   logic [SW-1:0] snap_s = '0;

   function automatic logic [DW-1:0] mem_rd(
      input logic [AW-1:0] a);
      return a ^ 32'hDEADBFEF;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: sim time exceeded");
      $fatal(1);
   end

   // Store buffer, LSU and dcache responder models
   initial begin
      ld_req = 0; ld_addr = '0; ld_sel = '0; ld_hit = 0;
      st_req = 0; st_addr = '0; st_wdata = '0; st_sel = '0;
      st_full = 0; st_empty = 1; fence = 0;
      dc_ack = 0; dc_rdata = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (pop_st && stbq.size() > 0) void'(stbq.pop_front());
         if (pop_ld && ldq.size() > 0) void'(ldq.pop_front());
         pop_st = 0;
         pop_ld = 0;
         fence = fence_req;
         if (fence_req) fence_cyc = cyc;
         fence_req = 0;
         if (dc_ack) begin
            dc_ack = 0;
            dc_rdata = $urandom;
         end else if (dc_req && wait_cnt >= dc_lat) begin
            dc_ack = 1;
            dc_rdata = dc_wen ? $urandom : mem_rd(dc_addr);
         end else begin
            dc_rdata = $urandom;
         end
         st_req   = stbq.size() > 0;
         st_empty = stbq.size() == 0;
         st_full  = stbq.size() >= DEP;
         if (st_req) begin
            st_addr = stbq[0].a;
            st_wdata = stbq[0].d;
            st_sel = stbq[0].s;
         end
         if (ldq.size() > 0 && !ld_req) ld_rise_cyc = cyc;
         ld_req = ldq.size() > 0;
         if (ld_req) begin
            ld_addr = ldq[0].a;
            ld_sel = ldq[0].s;
         end
         ld_hit = 0;
         foreach (stbq[i])
            if (ld_req && stbq[i].a == ld_addr) ld_hit = 1;
      end
   end

   // Rule monitor and transaction scoreboard
   initial begin
      bit exp_done;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            req_prev = 0; pend = 0; consec = 0;
            prev_hit = 0; prev_pend = 0; prev_ne = 0;
            wait_cnt = 0;
         end else begin
            if (dc_req && !req_prev) begin
               req_rise_cyc = cyc;
               snap_w = dc_wen; snap_a = dc_addr;
               snap_d = dc_wdata; snap_s = dc_sel;
               if (!dc_wen) begin
                  checks++;
                  if (prev_hit || prev_pend) begin
                     errors++;
                     $display("FAIL ld_grant_legal: addr=%h hit=%0d drain=%0d, need 0/0",
                              dc_addr, prev_hit, prev_pend);
                  end
                  if (prev_ne) consec++;
                  checks++;
                  if (consec > LIM) begin
                     errors++;
                     $display("FAIL starve_bound: %0d loads, limit %0d",
                              consec, LIM);
                  end
               end else begin
                  consec = 0;
               end
            end
            if (dc_req && dc_ack) begin
               if (req_rise_cyc != cyc) begin
                  checks++;
                  if ({dc_wen, dc_addr, dc_wdata, dc_sel} !==
                      {snap_w, snap_a, snap_d, snap_s}) begin
                     errors++;
                     $display("FAIL req_stable: got %h/%h, need %h/%h",
                              dc_addr, dc_wdata, snap_a, snap_d);
                  end
               end
               txlog.push_back('{dc_wen, dc_addr, dc_wdata});
               checks++;
               if (dc_wen) begin
                  if (stbq.size() == 0 || st_ack !== 1'b1 ||
                      ld_ack !== 1'b0 || dc_addr !== stbq[0].a ||
                      dc_wdata !== stbq[0].d ||
                      dc_sel !== stbq[0].s) begin
                     errors++;
                     $display("FAIL st_txn: got a=%h d=%h ack=%0d, need head of %0d",
                              dc_addr, dc_wdata, st_ack, stbq.size());
                  end
                  pop_st = 1;
               end else begin
                  if (ldq.size() == 0 || ld_ack !== 1'b1 ||
                      st_ack !== 1'b0 || dc_addr !== ldq[0].a ||
                      dc_sel !== ldq[0].s ||
                      ld_rdata !== mem_rd(dc_addr)) begin
                     errors++;
                     $display("FAIL ld_txn: got a=%h rd=%h ack=%0d, need rd=%h",
                              dc_addr, ld_rdata, ld_ack, mem_rd(dc_addr));
                  end
                  last_rd = ld_rdata;
                  pop_ld = 1;
               end
               if (rnd_lat) dc_lat = $urandom_range(0, 3);
            end else if (ld_ack || st_ack) begin
               checks++;
               errors++;
               $display("FAIL spurious_ack: ld=%0d st=%0d, need 0/0",
                        ld_ack, st_ack);
            end
            if (!ld_ack) begin
               checks++;
               if (ld_rdata !== '0) begin
                  errors++;
                  $display("FAIL rdata_idle: got %h, need 0", ld_rdata);
               end
            end
            if (st_ack) st_ack_cnt++;
            if (ld_ack) ld_ack_cnt++;
            exp_done = !dc_req && pend && st_empty;
            if (exp_done || done) begin
               checks++;
               if (done !== exp_done) begin
                  errors++;
                  $display("FAIL drain_done: got %0d, need %0d",
                           done, exp_done);
               end
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            prev_pend = pend;
            if (fence) pend = 1;
            else if (exp_done) pend = 0;
            prev_hit = ld_req && ld_hit && st_req;
            prev_ne = !st_empty;
            if (st_empty) consec = 0;
            if (!dc_req) wait_cnt = 0;
            else if (!dc_ack) wait_cnt++;
            req_prev = dc_req;
         end
      end
   end

   task automatic wait_quiet(input string nm, input int maxc);
      int n = 0;
      while ((stbq.size() != 0 || ldq.size() != 0 ||
              dc_req || pend) && n < maxc) begin
         @(negedge clk);
         n++;
      end
      if (n >= maxc) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: busy after %0d cycles, need idle",
                  nm, n);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ld_ack, ld_rdata, st_ack, done, dc_req, dc_wen,
           dc_addr, dc_wdata, dc_sel} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: req=%0d addr=%h, need all 0",
                  dc_req, dc_addr);
      end
      rst_n = 1;
      repeat (2) @(negedge clk);
      checks++;
      if (dc_req !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: req=%0d done=%0d, need 0/0",
                  dc_req, done);
      end
   endtask

   task automatic test_load_only();
      int l0 = ld_ack_cnt;
      dc_lat = 2;
      txlog.delete();
      ldq.push_back('{32'h100, 4'hF});
      wait_quiet("load_only", 50);
      checks++;
      if (txlog.size() != 1 || txlog[0].w !== 1'b0 ||
          txlog[0].a !== 32'h100) begin
         errors++;
         $display("FAIL load_only_txn: got %0d txns, need 1 load @100",
                  txlog.size());
      end
      checks++;
      if (req_rise_cyc != ld_rise_cyc + 1) begin
         errors++;
         $display("FAIL load_latency: req at %0d, need %0d",
                  req_rise_cyc, ld_rise_cyc + 1);
      end
      checks++;
      if (last_rd !== 32'hDEADBEEF || ld_ack_cnt != l0 + 1) begin
         errors++;
         $display("FAIL load_rdata: got %h x%0d, need DEADBEEF x1",
                  last_rd, ld_ack_cnt - l0);
      end
      checks++;
      if (dut.starve_cnt_q !== '0) begin
         errors++;
         $display("FAIL load_starve: got %0d, need 0",
                  dut.starve_cnt_q);
      end
   endtask

   task automatic test_starvation();
      bit exp_k [7] = '{0, 0, 0, 0, 1, 0, 0};
      int s0 = st_ack_cnt;
      dc_lat = 1;
      txlog.delete();
      stbq.push_back('{32'h300, 32'hCAFE0001, 4'hF});
      for (int i = 0; i < 6; i++)
         ldq.push_back('{32'h400 + 32'(4 * i), 4'h3});
      wait_quiet("starve", 200);
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (i >= txlog.size() || txlog[i].w !== exp_k[i]) begin
            errors++;
            $display("FAIL starve_order[%0d]: got w=%0d of %0d, need w=%0d",
                     i, (i < txlog.size()) ? txlog[i].w : 1'bx,
                     txlog.size(), exp_k[i]);
         end
      end
      checks++;
      if (st_ack_cnt != s0 + 1) begin
         errors++;
         $display("FAIL starve_stack: got %0d, need 1",
                  st_ack_cnt - s0);
      end
   endtask

   task automatic test_ordering();
      dc_lat = 1;
      txlog.delete();
      stbq.push_back('{32'h200, 32'h12345678, 4'hF});
      ldq.push_back('{32'h200, 4'hF});
      wait_quiet("order", 50);
      checks++;
      if (txlog.size() != 2 || txlog[0].w !== 1'b1 ||
          txlog[0].a !== 32'h200 || txlog[0].d !== 32'h12345678 ||
          txlog[1].w !== 1'b0 || txlog[1].a !== 32'h200) begin
         errors++;
         $display("FAIL order_seq: got %0d txns first w=%0d, need store then load",
                  txlog.size(), (txlog.size() > 0) ? txlog[0].w : 1'bx);
      end
   endtask

   task automatic test_full();
      bit exp_k [5] = '{1, 0, 1, 1, 1};
      logic [DW-1:0] d0;
      int n = 0;
      dc_lat = 3;
      txlog.delete();
      d0 = $urandom;
      stbq.push_back('{32'h500, d0, 4'h5});
      for (int i = 1; i < 4; i++)
         stbq.push_back('{32'h500 + 32'(4 * i), $urandom, 4'hF});
      ldq.push_back('{32'h600, 4'hF});
      while (!dc_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({dc_req, dc_wen, dc_addr, dc_wdata, dc_sel} !==
             {1'b1, 1'b1, 32'h500, d0, 4'h5}) begin
            errors++;
            $display("FAIL full_hold[%0d]: got %h/%h/%h, need 500/%h/5",
                     i, dc_addr, dc_wdata, dc_sel, d0);
         end
         @(negedge clk);
      end
      wait_quiet("full", 100);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i >= txlog.size() || txlog[i].w !== exp_k[i]) begin
            errors++;
            $display("FAIL full_order[%0d]: got %0d txns, need w=%0d",
                     i, txlog.size(), exp_k[i]);
         end
      end
   endtask

   task automatic test_fence();
      bit exp_k [4] = '{1, 1, 1, 0};
      int d0 = done_cnt;
      dc_lat = 1;
      txlog.delete();
      for (int i = 0; i < 3; i++)
         stbq.push_back('{32'h700 + 32'(4 * i), $urandom, 4'hF});
      fence_req = 1;
      @(negedge clk);
      ldq.push_back('{32'h800, 4'hF});
      wait_quiet("fence", 100);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= txlog.size() || txlog[i].w !== exp_k[i]) begin
            errors++;
            $display("FAIL fence_order[%0d]: got %0d txns, need w=%0d",
                     i, txlog.size(), exp_k[i]);
         end
      end
      checks++;
      if (done_cnt != d0 + 1 || req_rise_cyc != done_cyc + 2) begin
         errors++;
         $display("FAIL fence_done: got x%0d ld at %0d, need x1 ld at %0d",
                  done_cnt - d0, req_rise_cyc, done_cyc + 2);
      end
      d0 = done_cnt;
      fence_req = 1;
      repeat (4) @(negedge clk);
      checks++;
      if (done_cnt != d0 + 1 || done_cyc != fence_cyc + 1) begin
         errors++;
         $display("FAIL fence_empty: got x%0d at %0d, need x1 at %0d",
                  done_cnt - d0, done_cyc, fence_cyc + 1);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int s0;
      dc_lat = 20;
      stbq.push_back('{32'h900, 32'hA5A5A5A5, 4'hF});
      while (!dc_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      checks++;
      if ({ld_ack, st_ack, done, dc_req, dc_wen,
           dc_addr, dc_wdata, dc_sel} !== '0) begin
         errors++;
         $display("FAIL reset_async: req=%0d addr=%h, need all 0",
                  dc_req, dc_addr);
      end
      stbq.delete();
      ldq.delete();
      pop_st = 0;
      pop_ld = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      s0 = st_ack_cnt;
      dc_lat = 1;
      repeat (6) @(negedge clk);
      checks++;
      if (st_ack_cnt != s0 || dc_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_after: acks=%0d req=%0d, need 0/0",
                  st_ack_cnt - s0, dc_req);
      end
   endtask

   task automatic test_random();
      int s0 = st_ack_cnt;
      int l0 = ld_ack_cnt;
      int ns = 0;
      int nl = 0;
      rnd_lat = 1;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (stbq.size() < DEP && $urandom_range(0, 2) == 0) begin
            stbq.push_back('{32'h40 + 32'(4 * $urandom_range(0, 3)),
                             $urandom, 4'($urandom_range(1, 15))});
            ns++;
         end
         if (ldq.size() == 0 && $urandom_range(0, 1) == 0) begin
            ldq.push_back('{32'h40 + 32'(4 * $urandom_range(0, 3)),
                            4'($urandom_range(1, 15))});
            nl++;
         end
         if ($urandom_range(0, 39) == 0) fence_req = 1;
      end
      wait_quiet("random", 400);
      rnd_lat = 0;
      dc_lat = 1;
      checks++;
      if (st_ack_cnt - s0 != ns || ld_ack_cnt - l0 != nl) begin
         errors++;
         $display("FAIL random_count: got st=%0d ld=%0d, need st=%0d ld=%0d",
                  st_ack_cnt - s0, ld_ack_cnt - l0, ns, nl);
      end
   endtask

   initial begin
      test_reset();
      test_load_only();
      test_starvation();
      test_ordering();
      test_full();
      test_fence();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu_stb_dcache_arbiter.md
Name: lsu_stb_dcache_arbiter

Overview:
- Shares the single data-cache request port between LSU load requests and store-buffer drain writes.
- Sits between the LSU/store buffer and the dcache. Sequences retirement of the store-buffer head entry.
- Enforces load-after-store ordering, anti-starvation of stores and fence drain.

Parameters:
ADDR_W, 32, address width of load, store and dcache buses
DATA_W, 32, data width; byte-select width is DATA_W/8
STARVE_LIMIT, 4, consecutive load grants allowed while the store buffer is non-empty before a store is forced

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
lsu2arb_ld_req  in  1  load request; held until arb2lsu_ld_ack
lsu2arb_ld_addr  in  ADDR_W  load address
lsu2arb_ld_sel_byte  in  DATA_W/8  load byte select
ld_hit_stb  in  1  load address matches a pending store-buffer entry
arb2lsu_ld_ack  out  1  load complete; one-cycle pulse
arb2lsu_ld_rdata  out  DATA_W  load data; valid with arb2lsu_ld_ack
stb2arb_req  in  1  store-buffer head entry valid
stb2arb_addr  in  ADDR_W  head store address
stb2arb_wdata  in  DATA_W  head store data
stb2arb_sel_byte  in  DATA_W/8  head store byte select
stb_full  in  1  store buffer full
stb_empty  in  1  store buffer empty
arb2stb_ack  out  1  head entry written to dcache; pop the head
fence_drain_i  in  1  fence/flush request pulse
arb2lsu_drain_done  out  1  drain complete; one-cycle pulse
arb2dcache_req  out  1  dcache request
arb2dcache_w_en  out  1  1 = store, 0 = load
arb2dcache_addr  out  ADDR_W  request address
arb2dcache_wdata  out  DATA_W  store data
arb2dcache_sel_byte  out  DATA_W/8  byte select
dcache2arb_ack  in  1  dcache request complete
dcache2arb_rdata  in  DATA_W  dcache load data

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n.
- Reset state:
  - FSM goes to ARB_IDLE.
  - Every output is 0, including the registered dcache bus.
  - starve_cnt and drain_pending are 0.
- Reset asserted mid-transaction drops arb2dcache_req immediately. The dcache tolerates the abandoned request.
- FSM states: ARB_IDLE, ARB_LD_WAIT, ARB_ST_WAIT.
- ARB_IDLE grant priority, evaluated each cycle, first match wins:
  1. drain_pending && stb2arb_req -> store
  2. stb_full && stb2arb_req -> store
  3. starve_cnt == STARVE_LIMIT && stb2arb_req -> store
  4. lsu2arb_ld_req && ld_hit_stb && stb2arb_req -> store (ordering)
  5. lsu2arb_ld_req && !drain_pending -> load. This includes ld_hit_stb with the store buffer empty.
  6. stb2arb_req -> store (opportunistic)
  7. Otherwise stay in ARB_IDLE.
- On a grant, the arb2dcache_* registers load at the clock edge and the FSM moves to ARB_LD_WAIT or ARB_ST_WAIT. arb2dcache_req is asserted from the next cycle.
- Grant-to-request latency is 1 cycle.
- Request fields hold stable until dcache2arb_ack.
- ARB_LD_WAIT:
  - In the cycle dcache2arb_ack=1, arb2lsu_ld_ack=1 and arb2lsu_ld_rdata=dcache2arb_rdata, both combinational.
  - arb2dcache_req clears at the edge and the FSM returns to ARB_IDLE.
  - arb2lsu_ld_rdata is 0 when not acking.
- ARB_ST_WAIT: in the cycle dcache2arb_ack=1, arb2stb_ack=1 for exactly one cycle. Then clear the request and return to ARB_IDLE.
- Minimum spacing between back-to-back transactions is 1 idle cycle (the ARB_IDLE arbitration cycle).
- starve_cnt:
  - Saturates at STARVE_LIMIT; width is clog2(STARVE_LIMIT+1).
  - +1 on each load grant while stb_empty=0.
  - Clears on any store grant or whenever stb_empty=1.
- Drain:
  - fence_drain_i sets drain_pending at the edge; a pulse while already pending has no extra effect.
  - While drain_pending, no new load is granted. A load already in flight completes normally.
  - When the FSM is in ARB_IDLE, drain_pending=1 and stb_empty=1:
    - arb2lsu_drain_done=1 for one cycle.
    - drain_pending clears at the edge.
  - Fence with the store buffer already empty: done 1 cycle after the pulse.
- Simultaneous events:
  - fence_drain_i in the same cycle as an ARB_IDLE load grant: the load still wins that cycle. drain_pending takes effect from the next cycle.
  - stb_full together with ld_req: the store wins.
- dcache2arb_ack in ARB_IDLE is ignored.

Test Plan:
- Load only, stb_empty=1: ld_req addr 0x100, ack 2 cycles after req, rdata 0xDEADBEEF -> req rises 1 cycle after grant, w_en=0, ld_ack pulse with rdata 0xDEADBEEF, starve_cnt stays 0.
- Starvation: stb2arb_req=1 (not full, no hit) with ld_req held for 6 transactions -> 4 loads, then a store with arb2stb_ack pulse and w_en=1, then load again.
- Ordering: ld_req at 0x200 with ld_hit_stb=1, head store 0x200/0x12345678 -> store issued first and arb2stb_ack pulses; the load is issued only after the store is acked.
- Full: stb_full=1 with concurrent ld_req -> store granted, addr/wdata/sel_byte held stable across a 3-cycle ack delay.
- Fence: 3 entries in the buffer plus a pending ld_req, pulse fence_drain_i -> 3 stores, no load grant, drain_done pulses once when stb_empty=1, then the load is granted. Fence with an empty buffer -> drain_done 1 cycle later.
- Reset: assert rst_n=0 during ARB_ST_WAIT -> all outputs 0 asynchronously, FSM in ARB_IDLE, no arb2stb_ack after release.
